// File: rtl/i2s_transmitter_if.sv
// Sample-stream and I2S-link signal bundle for i2s_transmitter.
// master = sample source / link observer, slave = the transmitter itself.
interface i2s_transmitter_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] i_data_left;
    logic [DATA_WIDTH-1:0] i_data_right;
    logic                  i_data_valid;
    logic                  o_ready;
    logic                  o_bclk;
    logic                  o_lrclk;
    logic                  o_sdata;
    logic                  o_underrun;
    logic                  o_overflow;

    modport master (
        output i_data_left, i_data_right, i_data_valid,
        input  o_ready, o_bclk, o_lrclk, o_sdata, o_underrun, o_overflow
    );

    modport slave (
        input  i_data_left, i_data_right, i_data_valid,
        output o_ready, o_bclk, o_lrclk, o_sdata, o_underrun, o_overflow
    );
endinterface

// File: rtl/i2s_transmitter.sv
// Philips-timing I2S serialiser for 24-bit stereo samples with a one-deep holding register.
// Optional macro I2S_TX_REPEAT_ON_UNDERRUN_EN: on underrun, resend the last sample instead of muting.
module i2s_transmitter #(
    parameter int DATA_WIDTH       = 24,
    parameter int SLOT_BITS        = 32,
    parameter int BCLK_HALF_PERIOD = 4
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    i2s_transmitter_if.slave bus
);
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int FW         = $clog2(FRAME_BITS);
    localparam int HW         = (BCLK_HALF_PERIOD > 1) ? $clog2(BCLK_HALF_PERIOD) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(BCLK_HALF_PERIOD - 1);
    localparam logic [FW-1:0] F_LAST    = FW'(FRAME_BITS - 1);

    logic [HW-1:0]         half_cnt_reg;
    logic [FW-1:0]         f_reg;
    logic [FW-1:0]         f_next;
    logic                  bclk_reg;
    logic                  lrclk_reg;
    logic                  sdata_reg;
    logic                  ready_reg;
    logic                  underrun_reg;
    logic                  overflow_reg;
    logic                  hold_full_reg;
    logic                  full_next;
    logic [DATA_WIDTH-1:0] hold_left_reg;
    logic [DATA_WIDTH-1:0] hold_right_reg;
    logic [DATA_WIDTH-1:0] shift_left_reg;
    logic [DATA_WIDTH-1:0] shift_right_reg;
    logic [DATA_WIDTH-1:0] load_left;
    logic [DATA_WIDTH-1:0] load_right;
    logic                  fall;
    logic                  frame_load;
    logic                  left_bit;
    logic                  right_bit;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    logic [DATA_WIDTH-1:0] last_left_reg;
    logic [DATA_WIDTH-1:0] last_right_reg;
`endif

    always_comb begin
        // The cycle on which BCLK is about to fall is where all link outputs move.
        fall       = (half_cnt_reg == HALF_LAST) && bclk_reg;
        f_next     = (f_reg == F_LAST) ? '0 : f_reg + 1'b1;
        frame_load = fall && (f_next == '0);
        left_bit   = (f_next >= FW'(1)) && (f_next <= FW'(DATA_WIDTH));
        right_bit  = (f_next >= FW'(SLOT_BITS + 1)) && (f_next <= FW'(SLOT_BITS + DATA_WIDTH));

        full_next = hold_full_reg;
        if (bus.i_data_valid) begin
            full_next = 1'b1;
        end else if (frame_load) begin
            full_next = 1'b0;
        end

        load_left  = '0;
        load_right = '0;
        if (hold_full_reg) begin
            load_left  = hold_left_reg;
            load_right = hold_right_reg;
        end
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
        else begin
            load_left  = last_left_reg;
            load_right = last_right_reg;
        end
`endif
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            half_cnt_reg    <= '0;
            // Starting at the last frame bit makes the first falling edge land on f=0.
            f_reg           <= F_LAST;
            bclk_reg        <= 1'b0;
            lrclk_reg       <= 1'b0;
            sdata_reg       <= 1'b0;
            ready_reg       <= 1'b1;
            underrun_reg    <= 1'b0;
            overflow_reg    <= 1'b0;
            hold_full_reg   <= 1'b0;
            hold_left_reg   <= '0;
            hold_right_reg  <= '0;
            shift_left_reg  <= '0;
            shift_right_reg <= '0;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
            last_left_reg   <= '0;
            last_right_reg  <= '0;
`endif
        end else begin
            underrun_reg <= 1'b0;
            overflow_reg <= 1'b0;

            if (half_cnt_reg == HALF_LAST) begin
                half_cnt_reg <= '0;
                bclk_reg     <= !bclk_reg;
            end else begin
                half_cnt_reg <= half_cnt_reg + 1'b1;
            end

            if (fall) begin
                f_reg     <= f_next;
                lrclk_reg <= (f_next >= FW'(SLOT_BITS));
                if (frame_load) begin
                    shift_left_reg  <= load_left;
                    shift_right_reg <= load_right;
                    sdata_reg       <= 1'b0;
                    underrun_reg    <= !hold_full_reg;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
                    if (hold_full_reg) begin
                        last_left_reg  <= hold_left_reg;
                        last_right_reg <= hold_right_reg;
                    end
`endif
                end else if (left_bit) begin
                    sdata_reg      <= shift_left_reg[DATA_WIDTH-1];
                    shift_left_reg <= {shift_left_reg[DATA_WIDTH-2:0], 1'b0};
                end else if (right_bit) begin
                    sdata_reg       <= shift_right_reg[DATA_WIDTH-1];
                    shift_right_reg <= {shift_right_reg[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    sdata_reg <= 1'b0;
                end
            end

            // A load in the same cycle already consumed the old sample, so nothing is lost.
            if (bus.i_data_valid) begin
                hold_left_reg  <= bus.i_data_left;
                hold_right_reg <= bus.i_data_right;
                overflow_reg   <= hold_full_reg && !frame_load;
            end
            hold_full_reg <= full_next;
            ready_reg     <= !full_next;
        end
    end

    assign bus.o_bclk     = bclk_reg;
    assign bus.o_lrclk    = lrclk_reg;
    assign bus.o_sdata    = sdata_reg;
    assign bus.o_ready    = ready_reg;
    assign bus.o_underrun = underrun_reg;
    assign bus.o_overflow = overflow_reg;
endmodule

// File: tb/tb_i2s_transmitter.sv
// Scoreboard bench for i2s_transmitter: a stimulus process queues expected frames and flag pulses,
// a monitor deserialises the I2S link on BCLK rising edges and compares against those queues.
module tb_i2s_transmitter;
    localparam int DW = 24;
    localparam int SB = 32;
    localparam int HP = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2s_transmitter_if #(.DATA_WIDTH(DW)) bus ();

    i2s_transmitter #(
        .DATA_WIDTH       (DW),
        .SLOT_BITS        (SB),
        .BCLK_HALF_PERIOD (HP)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } frame_t;

    typedef struct {
        bit ovf;
        int cyc;
    } ev_t;

    frame_t frame_q[$];
    ev_t    ev_q[$];
    int     checks = 0;
    int     passed = 0;
    int     cyc;
    int     frames_seen = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic push_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
        frame_t f;
        f.l = l;
        f.r = r;
        frame_q.push_back(f);
    endtask

    task automatic push_ev(input bit ovf, input int c);
        ev_t e;
        e.ovf = ovf;
        e.cyc = c;
        ev_q.push_back(e);
    endtask

    task automatic handle_pulse(input bit ovf);
        ev_t e;
        if (ev_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected pulse: got %s at cycle %0d, required none",
                     ovf ? "overflow" : "underrun", cyc);
        end else begin
            e = ev_q.pop_front();
            check("pulse kind (1=overflow)", 64'(ovf), 64'(e.ovf));
            check("pulse cycle", 64'(cyc), 64'(e.cyc));
        end
    endtask

    // Link monitor: frame start is the first rising BCLK with LRCLK low after it was high.
    initial begin
        bit            prev_bclk;
        bit            prev_lr;
        bit            skip_first;
        bit            in_frame;
        bit            frame_ok;
        bit            lr;
        int            bi;
        logic [DW-1:0] got_l;
        logic [DW-1:0] got_r;
        frame_t        exp_f;
        prev_bclk = 0; prev_lr = 1; skip_first = 1; in_frame = 0; frame_ok = 1; bi = 0;
        got_l = '0; got_r = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_bclk = 0; prev_lr = 1; skip_first = 1; in_frame = 0; bi = 0;
            end else begin
                if (bus.o_underrun === 1'b1) handle_pulse(1'b0);
                if (bus.o_overflow === 1'b1) handle_pulse(1'b1);
                if (bus.o_bclk === 1'b1 && !prev_bclk) begin
                    if (skip_first) begin
                        skip_first = 0;
                    end else begin
                        lr = bus.o_lrclk;
                        if (!lr && prev_lr) begin
                            bi = 0; in_frame = 1; frame_ok = 1; got_l = '0; got_r = '0;
                        end else begin
                            bi++;
                        end
                        prev_lr = lr;
                        if (in_frame) begin
                            if (bi >= 1 && bi <= DW)
                                got_l = {got_l[DW-2:0], bus.o_sdata};
                            else if (bi >= SB + 1 && bi <= SB + DW)
                                got_r = {got_r[DW-2:0], bus.o_sdata};
                            else if (bus.o_sdata !== 1'b0)
                                frame_ok = 0;
                            if (lr !== (bi >= SB)) frame_ok = 0;
                            if (bi == 2 * SB - 1) begin
                                in_frame = 0;
                                if (frame_q.size() == 0) begin
                                    checks++;
                                    $display("FAIL unexpected frame: got L=%h R=%h, required none", got_l, got_r);
                                end else begin
                                    exp_f = frame_q.pop_front();
                                    $display("frame %0d: L=%h R=%h (required L=%h R=%h)",
                                             frames_seen, got_l, got_r, exp_f.l, exp_f.r);
                                    check($sformatf("frame %0d left", frames_seen), 64'(got_l), 64'(exp_f.l));
                                    check($sformatf("frame %0d right", frames_seen), 64'(got_r), 64'(exp_f.r));
                                    check($sformatf("frame %0d padding/lrclk", frames_seen), 64'(frame_ok), 64'd1);
                                end
                                frames_seen++;
                            end
                        end
                    end
                end
                prev_bclk = bus.o_bclk;
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Called at a negedge; the sample is captured on the following clock edge.
    task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
        bus.i_data_left  = l;
        bus.i_data_right = r;
        bus.i_data_valid = 1'b1;
        @(negedge clk);
        bus.i_data_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " bclk"},     64'(bus.o_bclk),     64'd0);
        check({tag, " lrclk"},    64'(bus.o_lrclk),    64'd0);
        check({tag, " sdata"},    64'(bus.o_sdata),    64'd0);
        check({tag, " ready"},    64'(bus.o_ready),    64'd1);
        check({tag, " underrun"}, 64'(bus.o_underrun), 64'd0);
        check({tag, " overflow"}, 64'(bus.o_overflow), 64'd0);
    endtask

    // BCLK after clock edge k is (k / HP) % 2: rises at HP, falls at 2*HP.
    task automatic check_bclk_start(input string tag);
        for (int k = 1; k <= 3 * HP; k++) begin
            @(negedge clk);
            check($sformatf("%s bclk after edge %0d", tag, k), 64'(bus.o_bclk), 64'((k / HP) % 2));
        end
    endtask

    localparam logic [DW-1:0] S1_L = 24'h123456;
    localparam logic [DW-1:0] S1_R = 24'h654321;
    localparam logic [DW-1:0] S2_L = 24'h800000;
    localparam logic [DW-1:0] S2_R = 24'h7FFFFE;

    initial begin
        bus.i_data_left  = '0;
        bus.i_data_right = '0;
        bus.i_data_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");

        // Idle frames 0 and 1: mute, underrun at each frame load (edge 4 + 256n).
        push_frame('0, '0);
        push_frame('0, '0);
        push_ev(1'b0, 4);
        push_ev(1'b0, 260);
        @(negedge clk);
        rst_n = 1'b1;
        check_bclk_start("start");

        // One sample during frame 1, sent in frame 2.
        push_frame(24'hA5A5A5, 24'h3C3C3C);
        wait_cyc(299);
        send(24'hA5A5A5, 24'h3C3C3C);
        check("ready after accept", 64'(bus.o_ready), 64'd0);
        wait_cyc(515);
        check("ready before load", 64'(bus.o_ready), 64'd0);
        wait_cyc(516);
        check("ready after load", 64'(bus.o_ready), 64'd1);

        // Two samples before one load: the second overwrites, overflow flagged.
        push_frame(24'h7FFFFF, 24'h7FFFFF);
        push_ev(1'b1, 610);
        wait_cyc(599);
        send(24'h000001, 24'h000001);
        wait_cyc(609);
        send(24'h7FFFFF, 24'h7FFFFF);

        // Sample arriving on the exact frame-load edge while holding is full.
        push_frame(S1_L, S1_R);
        push_frame(S2_L, S2_R);
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
        push_frame(S2_L, S2_R);
`else
        push_frame('0, '0);
`endif
        push_ev(1'b0, 1540);
        push_ev(1'b0, 1796);
        wait_cyc(799);
        send(S1_L, S1_R);
        wait_cyc(1027);
        send(S2_L, S2_R);
        check("ready with sample held at load", 64'(bus.o_ready), 64'd0);
        wait_cyc(1284);
        check("ready after second load", 64'(bus.o_ready), 64'd1);

        // Reset while f=10 of frame 7 (load at 1796, f=10 from edge 1836).
        wait_cyc(1838);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid-frame reset");
        repeat (3) @(negedge clk);
        push_frame('0, '0);
        push_ev(1'b0, 4);
        push_ev(1'b0, 260);
        rst_n = 1'b1;
        check_bclk_start("restart");
        wait_cyc(262);

        check("frames left unreceived", 64'(frame_q.size()), 64'd0);
        check("pulses left unseen", 64'(ev_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end
endmodule
